// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: the load/ready handshake with BCD digits and decimal
// points in, and multiplexed segment/anode drive plus the frame pulse out.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      load;
  logic                      ready;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  // Producer of digit data, consumer of the display drive.
  modport master (
    output load, digits_in, dp_in,
    input  ready, seg, dp, an, frame_done
  );

  // The scan driver itself.
  modport slave (
    input  load, digits_in, dp_in,
    output ready, seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-aligned updates.
// Digits are scanned one slot of REFRESH_DIV cycles each. Every slot opens with
// GUARD_CYCLES of all-anodes-off to prevent ghosting. New digits are taken through a
// load/ready handshake and only copied to the display at a frame boundary.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros (digit 0 always
// shows).
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned TickW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [TickW-1:0] GuardEnd = TickW'(GUARD_CYCLES);

  typedef enum logic [0:0] {StIdle, StPending} hs_state_e;

  hs_state_e state_q, state_d;

  logic [TickW-1:0] tick_q, tick_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             tick_wrap;
  logic             frame_end;

  logic [NUM_DIGITS-1:0][3:0] disp_q, pend_q;
  logic [NUM_DIGITS-1:0]      disp_dp_q, pend_dp_q;

  logic ready;
  logic accept;
  logic commit;

  logic [NUM_DIGITS-1:0] lz_blank;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00; // 10..15 are the blanking codes
    endcase
    return s;
  endfunction

  assign tick_wrap = (tick_q == TickLast);
  assign frame_end = tick_wrap && (idx_q == IdxLast);

  // Slot tick and digit index next state
  always_comb begin
    tick_d = tick_wrap ? '0 : tick_q + TickW'(1);
    idx_d  = idx_q;
    if (tick_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next state: a capture on a boundary cycle waits for the next boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.load) state_d = StPending;
      StPending: if (frame_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    ready  = (state_q == StIdle);
    accept = ready && bus.load;
    commit = (state_q == StPending) && frame_end;
  end

  // Pending and display digit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= {NUM_DIGITS{4'hF}};
      pend_dp_q <= '0;
      disp_q    <= {NUM_DIGITS{4'hF}};
      disp_dp_q <= '0;
    end else begin
      if (accept) begin
        pend_q    <= bus.digits_in;
        pend_dp_q <= bus.dp_in;
      end
      if (commit) begin
        disp_q    <= pend_q;
        disp_dp_q <= pend_dp_q;
      end
    end
  end

  // Per-digit leading-zero blanking mask
  always_comb begin
    lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic above_blank;
      above_blank = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
        if ((k > 0) && above_blank && (disp_q[k] == 4'd0)) begin
          lz_blank[k] = 1'b1;
        end
        above_blank = above_blank && ((disp_q[k] == 4'd0) || (disp_q[k] > 4'd9));
      end
    end
`endif
  end

  // Display drive next state: dark during the guard phase of each slot
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    if (tick_q >= GuardEnd) begin
      an_d  = NUM_DIGITS'(1) << idx_q;
      seg_d = lz_blank[idx_q] ? 7'h00 : bcd_to_seg(disp_q[idx_q]);
      dp_d  = disp_dp_q[idx_q];
    end
  end

  // Registered display drive and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_end;
    end
  end

  assign bus.ready      = ready;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios followed by random traffic, every cycle
// checked against a model that derives slot position from the cycle count since reset.
module tb_seg7_scan_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned DIV   = 8;
  localparam int unsigned GUARD = 2;
  localparam int unsigned FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  int unsigned     c;           // cycles since reset released
  logic [4*N-1:0]  m_disp, m_pend;
  logic [N-1:0]    m_disp_dp, m_pend_dp;
  bit              m_ready;
  logic [6:0]      e_seg;
  logic            e_dp;
  logic [N-1:0]    e_an;
  logic            e_fd;

  function automatic logic [6:0] ref_decode(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input int slot);
    int v;
    v = int'(m_disp[4*slot +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && v == 0) begin
      bit all_blank;
      all_blank = 1'b1;
      for (int j = slot + 1; j < int'(N); j++) begin
        int d;
        d = int'(m_disp[4*j +: 4]);
        if (d != 0 && d < 10) all_blank = 1'b0;
      end
      if (all_blank) return 7'h00;
    end
`endif
    return ref_decode(v);
  endfunction

  task automatic step(input bit do_load, input logic [4*N-1:0] din, input logic [N-1:0] dpin,
                      input bit do_rst);
    int  slot;
    int  tk;
    bit  boundary;
    bit  old_ready;
    bus.load      = do_load;
    bus.digits_in = din;
    bus.dp_in     = dpin;
    rst           = do_rst;
    @(posedge clk);
    if (do_rst) begin
      c         = 0;
      m_disp    = '1;
      m_pend    = '1;
      m_disp_dp = '0;
      m_pend_dp = '0;
      m_ready   = 1'b1;
      e_seg     = '0;
      e_dp      = 1'b0;
      e_an      = '0;
      e_fd      = 1'b0;
    end else begin
      tk       = int'(c % DIV);
      slot     = int'((c / DIV) % N);
      boundary = (tk == int'(DIV) - 1) && (slot == int'(N) - 1);
      if (tk < int'(GUARD)) begin
        e_an  = '0;
        e_seg = '0;
        e_dp  = 1'b0;
      end else begin
        e_an  = N'(1) << slot;
        e_seg = ref_seg(slot);
        e_dp  = m_disp_dp[slot];
      end
      e_fd      = boundary;
      old_ready = m_ready;
      if (do_load && old_ready) begin
        m_pend    = din;
        m_pend_dp = dpin;
        m_ready   = 1'b0;
      end
      if (boundary && !old_ready) begin
        m_disp    = m_pend;
        m_disp_dp = m_pend_dp;
        m_ready   = 1'b1;
      end
      c++;
    end
    #1;
    checks += 5;
    assert (bus.ready === m_ready) else begin
      failures++;
      $error("FAIL ready c=%0d got=%b want=%b", c, bus.ready, m_ready);
    end
    assert (bus.an === e_an) else begin
      failures++;
      $error("FAIL an c=%0d got=%b want=%b", c, bus.an, e_an);
    end
    assert (bus.seg === e_seg) else begin
      failures++;
      $error("FAIL seg c=%0d got=%h want=%h", c, bus.seg, e_seg);
    end
    assert (bus.dp === e_dp) else begin
      failures++;
      $error("FAIL dp c=%0d got=%b want=%b", c, bus.dp, e_dp);
    end
    assert (bus.frame_done === e_fd) else begin
      failures++;
      $error("FAIL frame_done c=%0d got=%b want=%b", c, bus.frame_done, e_fd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  // Advance until the next step() is the frame-boundary cycle
  task automatic to_boundary();
    for (int i = 0; i < 2 * int'(FRAME) && (c % FRAME) != FRAME - 1; i++) idle(1);
  endtask

  initial begin
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    rst           = 1'b1;
    c             = 0;

    // Reset, then two idle frames of blank digits
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    idle(2 * FRAME);

    // Mid-frame load of 1234 with dp on digit 2
    idle(5);
    step(1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(3);
    // Ignored while pending
    step(1'b1, 16'h9999, 4'b1111, 1'b0);
    idle(2 * FRAME);

    // Load exactly on a boundary cycle: commits at the following boundary
    to_boundary();
    step(1'b1, 16'h0087, 4'b0000, 1'b0);
    idle(2 * FRAME + 3);

    // Blank code in position 2
    step(1'b1, 16'h1A23, 4'b0001, 1'b0);
    idle(2 * FRAME);

    // Reset during slot 2 with data pending
    to_boundary();
    idle(2);
    step(1'b1, 16'h5678, 4'b1010, 1'b0);
    for (int i = 0; i < int'(FRAME) && ((c / DIV) % N) != 2; i++) idle(1);
    idle(3);
    step(1'b0, '0, '0, 1'b1);
    idle(2 * FRAME);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 6) == 0, 16'($urandom), 4'($urandom), ($urandom % 400) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
